// File: rtl/chess_clock_timer_if.sv
// Signal bundle between the game/turn logic and the chess clock timer.
// The master side drives the control strobes; the timer (slave) returns digits, flags and segments.
interface chess_clock_timer_if;
    logic       run;
    logic       newGame;
    logic       switchTurn;
    logic       activeBlack;
    logic [3:0] whiteMins;
    logic [3:0] whiteTens;
    logic [3:0] whiteUnits;
    logic [3:0] blackMins;
    logic [3:0] blackTens;
    logic [3:0] blackUnits;
    logic       whiteFlag;
    logic       blackFlag;
    logic [6:0] WhiteClockMins;
    logic [6:0] WhiteClockTensSec;
    logic [6:0] WhiteClockUnitsSec;

    modport master (
        output run, newGame, switchTurn,
        input  activeBlack, whiteMins, whiteTens, whiteUnits,
        input  blackMins, blackTens, blackUnits, whiteFlag, blackFlag,
        input  WhiteClockMins, WhiteClockTensSec, WhiteClockUnitsSec
    );

    modport slave (
        input  run, newGame, switchTurn,
        output activeBlack, whiteMins, whiteTens, whiteUnits,
        output blackMins, blackTens, blackUnits, whiteFlag, blackFlag,
        output WhiteClockMins, WhiteClockTensSec, WhiteClockUnitsSec
    );
endinterface

// File: rtl/chess_clock_timer.sv
// Dual m:ss countdown chess clock: only the side to move counts down, one decrement per prescaler tick.
// White's digits are also driven out as registered active-low 7-segment codes.
module chess_clock_timer #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int START_MINS = 5
) (
    input logic                clock,
    input logic                globalReset,
    chess_clock_timer_if.slave bus
);
    localparam int              PW        = $clog2(CLOCK_FREQ);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLOCK_FREQ - 1);
    localparam logic [3:0]      MINS0     = 4'(START_MINS);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_OVER} state_t;

    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_time_t;

    localparam bcd_time_t TIME0 = bcd_time_t'({MINS0, 8'h00});

    // One-second BCD decrement that saturates at 0:00.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.units != 4'd0) begin
            r.units = t.units - 4'd1;
        end else if (t.tens != 4'd0) begin
            r.units = 4'd9;
            r.tens  = t.tens - 4'd1;
        end else if (t.mins != 4'd0) begin
            r.units = 4'd9;
            r.tens  = 4'd5;
            r.mins  = t.mins - 4'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          active_black_q, active_black_d;
    bcd_time_t     white_time_q, white_time_d;
    bcd_time_t     black_time_q, black_time_d;
    logic          white_flag_q, white_flag_d;
    logic          black_flag_q, black_flag_d;
    logic [6:0]    seg_mins_q, seg_mins_d;
    logic [6:0]    seg_tens_q, seg_tens_d;
    logic [6:0]    seg_units_q, seg_units_d;

    logic      tick;
    bcd_time_t white_dec;
    bcd_time_t black_dec;

    assign tick      = (state_q == S_RUNNING) && (presc_q == PRESC_MAX);
    assign white_dec = dec_time(white_time_q);
    assign black_dec = dec_time(black_time_q);

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        active_black_d = active_black_q;
        white_time_d   = white_time_q;
        black_time_d   = black_time_q;
        white_flag_d   = white_flag_q;
        black_flag_d   = black_flag_q;
        seg_mins_d     = seg7(white_time_q.mins);
        seg_tens_d     = seg7(white_time_q.tens);
        seg_units_d    = seg7(white_time_q.units);

        if (bus.newGame) begin
            state_d        = S_IDLE;
            presc_d        = '0;
            active_black_d = 1'b0;
            white_time_d   = TIME0;
            black_time_d   = TIME0;
            white_flag_d   = 1'b0;
            black_flag_d   = 1'b0;
            seg_mins_d     = seg7(MINS0);
            seg_tens_d     = seg7(4'd0);
            seg_units_d    = seg7(4'd0);
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    if (bus.switchTurn) active_black_d = ~active_black_q;
                    if (bus.run) state_d = S_RUNNING;
                end
                S_RUNNING, S_PAUSED: begin
                    if (state_q == S_RUNNING) begin
                        presc_d = tick ? '0 : presc_q + 1'b1;
                        state_d = bus.run ? S_RUNNING : S_PAUSED;
                    end else if (bus.run) begin
                        state_d = S_RUNNING;
                    end
                    // The outgoing player is charged for the tick before the turn passes.
                    if (tick) begin
                        if (active_black_q) begin
                            black_time_d = black_dec;
                            if (black_dec == '0) begin
                                black_flag_d = 1'b1;
                                state_d      = S_OVER;
                            end
                        end else begin
                            white_time_d = white_dec;
                            if (white_dec == '0) begin
                                white_flag_d = 1'b1;
                                state_d      = S_OVER;
                            end
                        end
                    end
                    if (bus.switchTurn) begin
                        active_black_d = ~active_black_q;
                        presc_d        = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (globalReset) begin
            state_q        <= S_IDLE;
            presc_q        <= '0;
            active_black_q <= 1'b0;
            white_time_q   <= TIME0;
            black_time_q   <= TIME0;
            white_flag_q   <= 1'b0;
            black_flag_q   <= 1'b0;
            seg_mins_q     <= seg7(MINS0);
            seg_tens_q     <= seg7(4'd0);
            seg_units_q    <= seg7(4'd0);
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            active_black_q <= active_black_d;
            white_time_q   <= white_time_d;
            black_time_q   <= black_time_d;
            white_flag_q   <= white_flag_d;
            black_flag_q   <= black_flag_d;
            seg_mins_q     <= seg_mins_d;
            seg_tens_q     <= seg_tens_d;
            seg_units_q    <= seg_units_d;
        end
    end

    assign bus.activeBlack        = active_black_q;
    assign bus.whiteMins          = white_time_q.mins;
    assign bus.whiteTens          = white_time_q.tens;
    assign bus.whiteUnits         = white_time_q.units;
    assign bus.blackMins          = black_time_q.mins;
    assign bus.blackTens          = black_time_q.tens;
    assign bus.blackUnits         = black_time_q.units;
    assign bus.whiteFlag          = white_flag_q;
    assign bus.blackFlag          = black_flag_q;
    assign bus.WhiteClockMins     = seg_mins_q;
    assign bus.WhiteClockTensSec  = seg_tens_q;
    assign bus.WhiteClockUnitsSec = seg_units_q;
endmodule

// File: tb/tb_chess_clock_timer.sv
// Bench for chess_clock_timer: directed game scenarios with literal expectations, then random play,
// all checked every cycle against a seconds-based model of the two clocks.
module tb_chess_clock_timer;
    localparam int CF = 4;
    localparam int SM = 1;

    logic clock = 1'b0;
    logic globalReset;

    chess_clock_timer_if bus();

    chess_clock_timer #(.CLOCK_FREQ(CF), .START_MINS(SM)) dut (
        .clock(clock),
        .globalReset(globalReset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining seconds per player, turn, flags, and a phase counter within the current second.
    int         m_w, m_b, m_phase;
    bit         m_blk, m_wf, m_bf, m_started, m_prev_run, m_over;
    bit         m_counting, m_tick, m_over_now;
    bit         model_ok = 1'b0;
    logic [6:0] m_seg_m, m_seg_t, m_seg_u;

    always @(posedge clock) begin
        if (globalReset || bus.newGame) begin
            m_w = SM * 60; m_b = SM * 60; m_phase = 0;
            m_blk = 0; m_wf = 0; m_bf = 0; m_started = 0; m_prev_run = 0; m_over = 0;
            m_seg_m = seg_tab[SM]; m_seg_t = seg_tab[0]; m_seg_u = seg_tab[0];
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_seg_m = seg_tab[m_w / 60];
            m_seg_t = seg_tab[(m_w % 60) / 10];
            m_seg_u = seg_tab[m_w % 10];
            m_counting = m_started && m_prev_run && !m_over;
            m_tick     = m_counting && (m_phase == CF - 1);
            m_over_now = 1'b0;
            if (m_counting) m_phase = m_tick ? 0 : m_phase + 1;
            if (m_tick) begin
                if (m_blk) begin
                    if (m_b > 0) m_b--;
                    if (m_b == 0) begin m_bf = 1; m_over_now = 1; end
                end else begin
                    if (m_w > 0) m_w--;
                    if (m_w == 0) begin m_wf = 1; m_over_now = 1; end
                end
            end
            if (bus.switchTurn && !m_over) begin
                m_blk = !m_blk;
                if (m_started) m_phase = 0;
            end
            if (m_over_now) m_over = 1;
            m_started  = m_started || bus.run;
            m_prev_run = bus.run;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("whiteMins",   32'(bus.whiteMins),   32'(m_w / 60));
            chk("whiteTens",   32'(bus.whiteTens),   32'((m_w % 60) / 10));
            chk("whiteUnits",  32'(bus.whiteUnits),  32'(m_w % 10));
            chk("blackMins",   32'(bus.blackMins),   32'(m_b / 60));
            chk("blackTens",   32'(bus.blackTens),   32'((m_b % 60) / 10));
            chk("blackUnits",  32'(bus.blackUnits),  32'(m_b % 10));
            chk("whiteFlag",   32'(bus.whiteFlag),   32'(m_wf));
            chk("blackFlag",   32'(bus.blackFlag),   32'(m_bf));
            chk("activeBlack", 32'(bus.activeBlack), 32'(m_blk));
            chk("segMins",     32'(bus.WhiteClockMins),     32'(m_seg_m));
            chk("segTens",     32'(bus.WhiteClockTensSec),  32'(m_seg_t));
            chk("segUnits",    32'(bus.WhiteClockUnitsSec), 32'(m_seg_u));
        end
    end

    initial begin
        globalReset = 1'b1; bus.run = 1'b0; bus.newGame = 1'b0; bus.switchTurn = 1'b0;
        repeat (2) @(negedge clock);
        globalReset = 1'b0;
        chk("rst_wM", 32'(bus.whiteMins), 32'd1);
        chk("rst_wU", 32'(bus.whiteUnits), 32'd0);
        chk("rst_bM", 32'(bus.blackMins), 32'd1);
        chk("rst_act", 32'(bus.activeBlack), 32'd0);
        chk("rst_wF", 32'(bus.whiteFlag), 32'd0);
        chk("rst_segM", 32'(bus.WhiteClockMins), 32'h79);
        chk("rst_segT", 32'(bus.WhiteClockTensSec), 32'h40);

        // First second: one edge leaving idle, then a full prescaler period.
        bus.run = 1'b1;
        repeat (4) @(negedge clock);
        chk("pre_tick_wM", 32'(bus.whiteMins), 32'd1);
        @(negedge clock);
        chk("tick1_wM", 32'(bus.whiteMins), 32'd0);
        chk("tick1_wT", 32'(bus.whiteTens), 32'd5);
        chk("tick1_wU", 32'(bus.whiteUnits), 32'd9);
        chk("tick1_bM", 32'(bus.blackMins), 32'd1);
        chk("tick1_segM_lag", 32'(bus.WhiteClockMins), 32'h79);
        @(negedge clock);
        chk("tick1_segM", 32'(bus.WhiteClockMins), 32'h40);
        chk("tick1_segT", 32'(bus.WhiteClockTensSec), 32'h12);
        chk("tick1_segU", 32'(bus.WhiteClockUnitsSec), 32'h10);

        // switchTurn seen with prescaler at 2: black gets a full period.
        @(negedge clock);
        bus.switchTurn = 1'b1;
        @(negedge clock);
        bus.switchTurn = 1'b0;
        chk("sw_act", 32'(bus.activeBlack), 32'd1);
        repeat (3) @(negedge clock);
        chk("sw_bM_before", 32'(bus.blackMins), 32'd1);
        @(negedge clock);
        chk("sw_bT", 32'(bus.blackTens), 32'd5);
        chk("sw_bU", 32'(bus.blackUnits), 32'd9);
        chk("sw_wU", 32'(bus.whiteUnits), 32'd9);

        // switchTurn on the tick cycle: outgoing black pays, white untouched.
        repeat (3) @(negedge clock);
        bus.switchTurn = 1'b1;
        @(negedge clock);
        bus.switchTurn = 1'b0;
        chk("simul_bU", 32'(bus.blackUnits), 32'd8);
        chk("simul_act", 32'(bus.activeBlack), 32'd0);
        chk("simul_wU", 32'(bus.whiteUnits), 32'd9);

        // Pause with prescaler at 2, then resume.
        repeat (2) @(negedge clock);
        bus.run = 1'b0;
        repeat (10) @(negedge clock);
        chk("pause_wU", 32'(bus.whiteUnits), 32'd9);
        bus.run = 1'b1;
        @(negedge clock);
        chk("resume1_wU", 32'(bus.whiteUnits), 32'd9);
        @(negedge clock);
        chk("resume2_wU", 32'(bus.whiteUnits), 32'd8);

        bus.newGame = 1'b1;
        @(negedge clock);
        bus.newGame = 1'b0;
        chk("ng_wM", 32'(bus.whiteMins), 32'd1);
        chk("ng_bU", 32'(bus.blackUnits), 32'd0);
        chk("ng_act", 32'(bus.activeBlack), 32'd0);
        chk("ng_segM", 32'(bus.WhiteClockMins), 32'h79);
        chk("ng_segU", 32'(bus.WhiteClockUnitsSec), 32'h40);

        for (int i = 0; i < 4000; i++) begin
            bus.run         = ($urandom_range(0, 9) != 0);
            bus.switchTurn  = ($urandom_range(0, 24) == 0);
            bus.newGame     = ($urandom_range(0, 799) == 0);
            globalReset     = ($urandom_range(0, 1499) == 0);
            @(negedge clock);
        end

        // Run white out of time from a fresh game.
        globalReset = 1'b0; bus.switchTurn = 1'b0; bus.run = 1'b0;
        bus.newGame = 1'b1;
        @(negedge clock);
        bus.newGame = 1'b0;
        bus.run = 1'b1;
        repeat (240) @(negedge clock);
        chk("last_wU", 32'(bus.whiteUnits), 32'd1);
        chk("last_wF", 32'(bus.whiteFlag), 32'd0);
        @(negedge clock);
        chk("out_wU", 32'(bus.whiteUnits), 32'd0);
        chk("out_wM", 32'(bus.whiteMins), 32'd0);
        chk("out_wF", 32'(bus.whiteFlag), 32'd1);
        chk("out_bM", 32'(bus.blackMins), 32'd1);
        repeat (6) @(negedge clock);
        chk("over_wT", 32'(bus.whiteTens), 32'd0);
        bus.switchTurn = 1'b1;
        @(negedge clock);
        bus.switchTurn = 1'b0;
        @(negedge clock);
        chk("over_act", 32'(bus.activeBlack), 32'd0);
        chk("over_wF", 32'(bus.whiteFlag), 32'd1);

        globalReset = 1'b1;
        @(negedge clock);
        globalReset = 1'b0;
        chk("gr_wF", 32'(bus.whiteFlag), 32'd0);
        chk("gr_segM", 32'(bus.WhiteClockMins), 32'h79);
        chk("gr_segT", 32'(bus.WhiteClockTensSec), 32'h40);
        chk("gr_segU", 32'(bus.WhiteClockUnitsSec), 32'h40);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
